// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline stages, the arbiter and the single-port memory.
// slave: arbiter view; master: environment (stages + memory) view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_err;
  logic          if_stall;
  logic          dm_req;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          dm_err;
  logic          dm_stall;
  logic          halt;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_dump;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, halt, mem_done, mem_rdata,
    output if_rdata, if_done, if_err, if_stall, dm_rdata, dm_done, dm_err, dm_stall,
    output mem_en, mem_wr, mem_addr, mem_wdata, mem_dump
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, halt, mem_done, mem_rdata,
    input  if_rdata, if_done, if_err, if_stall, dm_rdata, dm_done, dm_err, dm_stall,
    input  mem_en, mem_wr, mem_addr, mem_wdata, mem_dump
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (read) and data (read/write) with a fairness limit.
// Define ALIGN_CHECK_EN to fail odd addresses immediately (err=1) without touching memory.
module mem_port_arbiter #(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16,
  parameter int unsigned FAIR_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned   SW        = $clog2(FAIR_LIMIT + 1);
  localparam logic [SW-1:0] StreakMax = SW'(FAIR_LIMIT);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StIssue  = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StResp   = 3'd3;
  localparam logic [2:0] StDump   = 3'd4;
  localparam logic [2:0] StHalted = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          owner_dm_q, owner_dm_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          grant_dm, grant_if, fetch_due, resp;
`ifdef ALIGN_CHECK_EN
  logic          err_q, err_d;
`endif

  assign fetch_due = bus.if_req && (streak_q == StreakMax);

  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    streak_d   = streak_q;
    grant_dm   = 1'b0;
    grant_if   = 1'b0;
`ifdef ALIGN_CHECK_EN
    err_d      = err_q;
`endif
    case (state_q)
      StIdle: begin
        // Data normally wins; halt waits for any pending data access to drain first.
        if (bus.dm_req && !fetch_due) begin
          grant_dm = 1'b1;
        end else if (bus.halt && !bus.dm_req) begin
          state_d = StDump;
        end else if (bus.if_req) begin
          grant_if = 1'b1;
        end
        if (grant_dm || grant_if) begin
          owner_dm_d = grant_dm;
          wr_d       = grant_dm & bus.dm_wr;
          addr_d     = grant_dm ? bus.dm_addr : bus.if_addr;
          wdata_d    = grant_dm ? bus.dm_wdata : '0;
          state_d    = StIssue;
          if (grant_dm && bus.if_req) begin
            streak_d = (streak_q == StreakMax) ? StreakMax : streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
`ifdef ALIGN_CHECK_EN
          err_d = addr_d[0];
          if (addr_d[0]) begin
            rdata_d = '0;
            state_d = StResp;
          end
`endif
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (bus.mem_done) begin
          rdata_d = bus.mem_rdata;
          state_d = StResp;
        end
      end
      StResp:   state_d = StIdle;
      StDump:   state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_dm_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      streak_q   <= '0;
`ifdef ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      streak_q   <= streak_d;
`ifdef ALIGN_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign resp          = (state_q == StResp);
  assign bus.mem_en    = (state_q == StIssue);
  assign bus.mem_wr    = bus.mem_en & owner_dm_q & wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_dump  = (state_q == StDump);
  assign bus.if_done   = resp & ~owner_dm_q;
  assign bus.dm_done   = resp & owner_dm_q;
  assign bus.if_rdata  = rdata_q;
  assign bus.dm_rdata  = rdata_q;
  assign bus.if_stall  = bus.if_req & ~bus.if_done;
  assign bus.dm_stall  = bus.dm_req & ~bus.dm_done;
`ifdef ALIGN_CHECK_EN
  assign bus.if_err    = bus.if_done & err_q;
  assign bus.dm_err    = bus.dm_done & err_q;
`else
  assign bus.if_err    = 1'b0;
  assign bus.dm_err    = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences, randomized traffic
// against a transaction-level arbitration/memory model.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned FL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_port_arbiter #(.AW(AW), .DW(DW), .FAIR_LIMIT(FL)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] init_word(input int i);
    if (i == 8) return 16'hBEEF;
    return 16'(32'h1000 + i * 7);
  endfunction

  function automatic int idx(input logic [15:0] a);
    return int'(a[8:1]);
  endfunction

  // Memory responder: mem_done arrives lat cycles after the mem_en cycle.
  logic [15:0] mem_arr [256];
  logic [7:0]  rd_idx;
  int          lat = 1;
  int          cnt;
  logic        ovr = 1'b0;
  logic        ovr_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 0;
      rd_idx <= '0;
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
    end else if (bus.mem_en) begin
      cnt    <= lat;
      rd_idx <= bus.mem_addr[8:1];
      if (bus.mem_wr) mem_arr[bus.mem_addr[8:1]] <= bus.mem_wdata;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end
  end

  assign bus.mem_done  = ovr ? ovr_done : (cnt == 1);
  assign bus.mem_rdata = mem_arr[rd_idx];

  logic [15:0] ref_mem [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_wr    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    bus.halt     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    ovr = 1'b0;
    ovr_done = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  typedef struct {
    logic        dm;
    logic        wr;
    logic [15:0] dma;
    logic [15:0] wd;
    logic        fi;
    logic [15:0] ia;
    int          lat;
    logic        exp_dm;
    logic        chk_rd;
    logic [15:0] exp_rd;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input int k, input vec_t v);
    int   en_cnt, en_at;
    logic got, en_wr;
    logic [15:0] en_addr, en_wdata;
    en_cnt = 0; en_at = -1; got = 1'b0;
    en_wr = 1'b0; en_addr = '0; en_wdata = '0;
    do_reset();
    lat          = v.lat;
    bus.dm_req   = v.dm;
    bus.dm_wr    = v.wr;
    bus.dm_addr  = v.dma;
    bus.dm_wdata = v.wd;
    bus.if_req   = v.fi;
    bus.if_addr  = v.ia;
    for (int n = 1; n <= 30 && !got; n++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        en_cnt++; en_at = n - 1;
        en_wr = bus.mem_wr; en_addr = bus.mem_addr; en_wdata = bus.mem_wdata;
      end
      if (bus.dm_done || bus.if_done) begin
        got = 1'b1;
        chk($sformatf("vec%0d_dm_done", k), bus.dm_done, v.exp_dm);
        chk($sformatf("vec%0d_if_done", k), bus.if_done, !v.exp_dm);
        if (v.chk_rd)
          chk($sformatf("vec%0d_rdata", k), v.exp_dm ? bus.dm_rdata : bus.if_rdata, v.exp_rd);
        chk($sformatf("vec%0d_latency", k), n - 1, v.exp_cyc);
        chk($sformatf("vec%0d_owner_stall", k), v.exp_dm ? bus.dm_stall : bus.if_stall, 0);
        chk($sformatf("vec%0d_err", k), {bus.if_err, bus.dm_err}, 0);
      end else begin
        if (v.dm) chk($sformatf("vec%0d_dm_stall", k), bus.dm_stall, 1);
        if (v.fi) chk($sformatf("vec%0d_if_stall", k), bus.if_stall, 1);
      end
    end
    chk($sformatf("vec%0d_done_seen", k), got, 1);
    chk($sformatf("vec%0d_en_count", k), en_cnt, 1);
    chk($sformatf("vec%0d_en_cycle", k), en_at, 1);
    chk($sformatf("vec%0d_mem_addr", k), en_addr, v.exp_dm ? v.dma : v.ia);
    chk($sformatf("vec%0d_mem_wr", k), en_wr, v.exp_dm & v.wr);
    if (v.exp_dm && v.wr) chk($sformatf("vec%0d_mem_wdata", k), en_wdata, v.wd);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Randomized-phase state
  logic        prev_if, prev_dm, outstanding, own_dm, exp_chk_rd, done_if, done_dm;
  logic [15:0] exp_rd;
  int          streak_m, cyc, g_cyc, g_lat, if_wait, dm_wait, max_if_wait, max_dm_wait, ngrants;

  initial begin : main
    logic got, exp_dm, got_dm;
    int   dumps, ens, grants, done_at, dump_at;
    idle_inputs();

    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1, 1'b1, 1'b1, 16'hBEEF, 3};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0040, 1, 1'b0, 1'b1,
                init_word(idx(16'h0040)), 3};
    vecs[2] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h0040, 1, 1'b1, 1'b1,
                init_word(idx(16'h0030)), 3};
    vecs[3] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000, 2, 1'b1, 1'b0, 16'h0000, 4};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0022, 5, 1'b0, 1'b1,
                init_word(idx(16'h0022)), 7};
    vecs[5] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 3, 1'b1, 1'b1, 16'hBEEF, 5};
    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Reset in the middle of WAIT, then a stray mem_done while IDLE.
    do_reset();
    lat = 10;
    bus.dm_req = 1'b1; bus.dm_addr = 16'h0010;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      got = bus.mem_en;
    end
    chk("rst_issue_seen", got, 1);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rst_outputs_zero", {bus.if_done, bus.if_err, bus.if_stall, bus.dm_done, bus.dm_err,
        bus.dm_stall, bus.mem_en, bus.mem_wr, bus.mem_dump, |bus.mem_addr, |bus.mem_wdata,
        |bus.if_rdata, |bus.dm_rdata}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ovr = 1'b1; ovr_done = 1'b1;
    @(posedge clk); #1;
    ovr_done = 1'b0;
    ens = 0; dumps = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.mem_en) ens++;
      if (bus.dm_done || bus.if_done) dumps++;
    end
    chk("rst_no_mem_en", ens, 0);
    chk("rst_no_done", dumps, 0);
    ovr = 1'b0;

    // Both requestors held continuously: D,D,D,D,F repeating.
    do_reset();
    lat = 1;
    bus.dm_req = 1'b1; bus.dm_addr = 16'h0100;
    bus.if_req = 1'b1; bus.if_addr = 16'h0040;
    grants = 0;
    for (int n = 0; n < 200 && grants < 10; n++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        chk($sformatf("fair_grant%0d", grants), bus.mem_addr == 16'h0100,
            (grants % (FL + 1)) != FL);
        grants++;
      end
    end
    chk("fair_grant_count", grants, 10);
    @(posedge clk); #1;
    idle_inputs();

    // Write with halt pending: write completes, then exactly one dump, then nothing granted.
    do_reset();
    lat = 1;
    bus.dm_req = 1'b1; bus.dm_wr = 1'b1; bus.dm_addr = 16'h0020; bus.dm_wdata = 16'h1234;
    bus.halt = 1'b1;
    got = 1'b0; ens = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        ens++;
        chk("halt_mem_wr", bus.mem_wr, 1);
        chk("halt_mem_wdata", bus.mem_wdata, 16'h1234);
      end
      if (bus.mem_dump) dumps++;
      got = bus.dm_done;
    end
    chk("halt_dm_done", got, 1);
    chk("halt_write_issued", ens, 1);
    @(posedge clk); #1;
    bus.dm_req = 1'b0; bus.dm_wr = 1'b0;
    dumps = 0; ens = 0; dump_at = -1; done_at = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.mem_dump) begin dumps++; dump_at = n; end
      if (bus.mem_en) ens++;
      if (bus.dm_done || bus.if_done) done_at++;
      @(posedge clk); #1;
      if (n == 3) begin bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dm_addr = 16'h0030; end
    end
    chk("halt_dump_count", dumps, 1);
    chk("halt_dump_cycle", dump_at, 1);
    chk("halt_no_grant", ens, 0);
    chk("halt_no_done", done_at, 0);
    @(negedge clk);
    chk("halt_stalls", {bus.if_stall, bus.dm_stall}, 2'b11);
    chk("halt_mem_written", mem_arr[idx(16'h0020)], 16'h1234);
    @(posedge clk); #1;
    idle_inputs();

    // Odd data address.
    do_reset();
    lat = 1;
    bus.dm_req = 1'b1; bus.dm_addr = 16'h0021;
    got = 1'b0; ens = 0; done_at = -1;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (bus.mem_en) ens++;
      if (bus.dm_done) begin
        got = 1'b1; done_at = n - 1;
`ifdef ALIGN_CHECK_EN
        chk("align_err", bus.dm_err, 1);
        chk("align_rdata", bus.dm_rdata, 0);
`else
        chk("unalign_err", bus.dm_err, 0);
        chk("unalign_rdata", bus.dm_rdata, init_word(idx(16'h0021)));
`endif
      end
    end
    chk("odd_done_seen", got, 1);
`ifdef ALIGN_CHECK_EN
    chk("align_no_mem_en", ens, 0);
    chk("align_fast", (done_at >= 1) && (done_at <= 2), 1);
`else
    chk("unalign_mem_en", ens, 1);
    chk("unalign_latency", done_at, 3);
`endif
    @(posedge clk); #1;
    idle_inputs();

    // Randomized traffic against the transaction-level model.
    do_reset();
    prev_if = 1'b0; prev_dm = 1'b0; outstanding = 1'b0; own_dm = 1'b0;
    done_if = 1'b0; done_dm = 1'b0; exp_chk_rd = 1'b0; exp_rd = '0;
    streak_m = 0; cyc = 0; g_cyc = 0; g_lat = 0; ngrants = 0;
    if_wait = 0; dm_wait = 0; max_if_wait = 0; max_dm_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cyc++;
      if (bus.dm_done || bus.if_done) begin
        chk("rnd_done_owner", {bus.if_done, bus.dm_done},
            outstanding ? (own_dm ? 2'b01 : 2'b10) : 2'b00);
        chk("rnd_latency", cyc - g_cyc, g_lat + 1);
        if (exp_chk_rd) chk("rnd_rdata", own_dm ? bus.dm_rdata : bus.if_rdata, exp_rd);
        if (bus.if_done) begin done_if = 1'b1; if_wait = 0; end
        if (bus.dm_done) begin done_dm = 1'b1; dm_wait = 0; end
        outstanding = 1'b0;
      end
      if (bus.mem_en) begin
        chk("rnd_no_overlap", outstanding, 0);
        exp_dm = prev_dm && !(streak_m == FL && prev_if);
        got_dm = bus.mem_addr[8];
        chk("rnd_winner", got_dm, exp_dm);
        chk("rnd_mem_addr", bus.mem_addr, got_dm ? bus.dm_addr : bus.if_addr);
        chk("rnd_mem_wr", bus.mem_wr, got_dm && bus.dm_wr);
        if (got_dm) streak_m = prev_if ? ((streak_m < FL) ? streak_m + 1 : FL) : 0;
        else        streak_m = 0;
        exp_rd     = ref_mem[idx(bus.mem_addr)];
        exp_chk_rd = !(got_dm && bus.dm_wr);
        if (got_dm && bus.dm_wr) begin
          chk("rnd_mem_wdata", bus.mem_wdata, bus.dm_wdata);
          ref_mem[idx(bus.mem_addr)] = bus.dm_wdata;
        end
        outstanding = 1'b1; own_dm = got_dm; g_cyc = cyc; g_lat = lat;
        ngrants++;
      end
      if (bus.if_req && !bus.if_done) if_wait++;
      if (bus.dm_req && !bus.dm_done) dm_wait++;
      if (if_wait > max_if_wait) max_if_wait = if_wait;
      if (dm_wait > max_dm_wait) max_dm_wait = dm_wait;
      prev_if = bus.if_req;
      prev_dm = bus.dm_req;
      @(posedge clk); #1;
      lat = int'($urandom_range(1, 4));
      if (bus.if_req) begin
        if (done_if) begin
          done_if = 1'b0;
          if ($urandom_range(0, 1) == 0) bus.if_req = 1'b0;
          else bus.if_addr = {8'h00, 7'($urandom), 1'b0};
        end
      end else if ($urandom_range(0, 9) < 4) begin
        bus.if_req  = 1'b1;
        bus.if_addr = {8'h00, 7'($urandom), 1'b0};
      end
      if (bus.dm_req) begin
        if (done_dm) begin
          done_dm = 1'b0;
          if ($urandom_range(0, 1) == 0) bus.dm_req = 1'b0;
          else begin
            bus.dm_wr = 1'($urandom); bus.dm_addr = {8'h01, 7'($urandom), 1'b0};
            bus.dm_wdata = 16'($urandom);
          end
        end
      end else if ($urandom_range(0, 9) < 6) begin
        bus.dm_req = 1'b1; bus.dm_wr = 1'($urandom);
        bus.dm_addr = {8'h01, 7'($urandom), 1'b0}; bus.dm_wdata = 16'($urandom);
      end
    end
    chk("rnd_grant_volume", ngrants > 200, 1);
    chk("rnd_if_max_wait", max_if_wait <= 60, 1);
    chk("rnd_dm_max_wait", max_dm_wait <= 60, 1);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
